// File: rtl/conv_z_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : conv_pkg
// Description : Shared defaults, shape encoding and FSM state encoding for
//               the convolver Z-result streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  // Default widths, matching the convolver core's Z memory interface
  localparam int unsigned CONV_DATA_W     = 16;
  localparam int unsigned CONV_ADDR_W     = 6;
  localparam int unsigned CONV_FIFO_DEPTH = 8;

  // Convolution shape select
  localparam logic SHAPE_FULL = 1'b1;  // len = sizeX + sizeY - 1
  localparam logic SHAPE_SAME = 1'b0;  // len = sizeX

  // Streamer control states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_z_streamer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : conv_stream_fifo
// Description : Synchronous FIFO with first-word fall-through head read.
//               Occupancy uses one extra pointer bit. A push while full is
//               dropped unless a pop happens in the same cycle.
// Ports       : clk, rstn      - clock, async active-low reset
//               push_i/data_i  - write strobe and data
//               pop_i          - remove head entry (ignored when empty)
//               data_o         - head entry (valid when !empty_o)
//               full_o/empty_o - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module conv_stream_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so full+push+pop still writes.
  assign do_push = push_i & (~full_o | do_pop);

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule : conv_stream_fifo
`default_nettype wire

// File: rtl/conv_z_streamer.sv
`default_nettype none
// ============================================================================
// Module      : conv_z_streamer
// Description : Captures convolver Z writes, buffers them in a small FIFO and
//               streams them out on a valid/ready interface with last/index.
//               Output length is latched from shape/sizes on start_i.
// Ports       : clk, rstn                 - clock, async active-low reset
//               start_i, shape_i, sizeX_i, sizeY_i - run start and geometry
//               z_we_i, z_addr_i, z_data_i - convolver Z write port (snooped)
//               conv_done_i               - convolver done pulse
//               m_valid_o/m_ready_i/m_data_o/m_last_o/m_index_o - stream out
//               busy_o, done_o            - status
//               ovf_o, order_err_o, len_err_o - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module conv_z_streamer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W     = CONV_DATA_W,
  parameter int unsigned ADDR_W     = CONV_ADDR_W,
  parameter int unsigned FIFO_DEPTH = CONV_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              shape_i,
  input  logic [4:0]        sizeX_i,
  input  logic [4:0]        sizeY_i,
  input  logic              z_we_i,
  input  logic [ADDR_W-1:0] z_addr_i,
  input  logic [DATA_W-1:0] z_data_i,
  input  logic              conv_done_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic [ADDR_W-1:0] m_index_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic              order_err_o,
  output logic              len_err_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] in_cnt_q, in_cnt_d;
  logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
  logic              ovf_q, ovf_d;
  logic              order_err_q, order_err_d;
  logic              len_err_q, len_err_d;

  logic [ADDR_W-1:0] len;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  // ---------------------------------------------------------------------------
  // Output length from the geometry presented with start_i
  // ---------------------------------------------------------------------------
  always_comb begin
    len = '0;
    if (sizeX_i == 5'd0 || sizeY_i == 5'd0) begin
      len = '0;
    end else if (shape_i == SHAPE_FULL) begin
      len = ADDR_W'(sizeX_i) + ADDR_W'(sizeY_i) - ADDR_W'(1);
    end else begin
      len = ADDR_W'(sizeX_i);
    end
  end

  // ---------------------------------------------------------------------------
  // Result buffer
  // ---------------------------------------------------------------------------
  conv_stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifo_push),
    .data_i  (z_data_i),
    .pop_i   (fifo_pop),
    .data_o  (m_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_valid_o   = ~fifo_empty;
  assign fifo_pop    = m_valid_o & m_ready_i;
  assign m_index_o   = out_cnt_q;
  assign m_last_o    = m_valid_o & (out_cnt_q == (target_q - ADDR_W'(1)));
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign ovf_o       = ovf_q;
  assign order_err_o = order_err_q;
  assign len_err_o   = len_err_q;

  // ---------------------------------------------------------------------------
  // Control FSM, counters and sticky flags
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = fifo_pop ? (out_cnt_q + ADDR_W'(1)) : out_cnt_q;
    ovf_d       = ovf_q;
    order_err_d = order_err_q;
    len_err_d   = len_err_q;
    fifo_push   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          target_d    = len;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          ovf_d       = 1'b0;
          order_err_d = 1'b0;
          len_err_d   = 1'b0;
          state_d     = (len == '0) ? ST_DONE : ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (z_we_i) begin
          fifo_push = 1'b1;
          in_cnt_d  = in_cnt_q + ADDR_W'(1);
          if (z_addr_i != in_cnt_q) order_err_d = 1'b1;
          // The FIFO silently drops this one; in_cnt still advances so the
          // run can close on the expected length.
          if (fifo_full && !fifo_pop) ovf_d = 1'b1;
        end
        if (in_cnt_d == target_q) begin
          state_d = ST_DRAIN;
        end else if (conv_done_i) begin
          len_err_d = 1'b1;
          target_d  = in_cnt_d;
          state_d   = (in_cnt_d == '0) ? ST_DONE : ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Leaving on an empty buffer covers runs whose last beat can never be
        // flagged: samples lost to overflow, or a truncated run whose beats
        // were all consumed before conv_done_i shortened the target.
        if ((fifo_pop && m_last_o) || fifo_empty) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      order_err_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      ovf_q       <= ovf_d;
      order_err_q <= order_err_d;
      len_err_q   <= len_err_d;
    end
  end

endmodule : conv_z_streamer
`default_nettype wire

// File: tb/tb_conv_z_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_z_streamer
// Description : Directed testbench for conv_z_streamer. Stimulus pushes the
//               hand-computed expected beats into a queue; a monitor pops and
//               compares on every accepted output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_z_streamer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 6;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] index;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start_i;
  logic              shape_i;
  logic [4:0]        sizeX_i;
  logic [4:0]        sizeY_i;
  logic              z_we_i;
  logic [ADDR_W-1:0] z_addr_i;
  logic [DATA_W-1:0] z_data_i;
  logic              conv_done_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o;
  logic [ADDR_W-1:0] m_index_o;
  logic              busy_o;
  logic              done_o;
  logic              ovf_o;
  logic              order_err_o;
  logic              len_err_o;

  int    n_pass  = 0;
  int    n_total = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  conv_z_streamer #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .shape_i     (shape_i),
    .sizeX_i     (sizeX_i),
    .sizeY_i     (sizeY_i),
    .z_we_i      (z_we_i),
    .z_addr_i    (z_addr_i),
    .z_data_i    (z_data_i),
    .conv_done_i (conv_done_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .m_index_o   (m_index_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ovf_o       (ovf_o),
    .order_err_o (order_err_o),
    .len_err_o   (len_err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: inputs change 1 time unit after posedge, so at negedge the
  // handshake seen here is the one that completes on the next posedge.
  always @(negedge clk) begin
    if (rstn && m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {16'd0, m_data_o}, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data",  {16'd0, m_data_o}, {16'd0, e.data});
        chk("beat_index", {26'd0, m_index_o}, {26'd0, e.index});
        chk("beat_last",  {31'd0, m_last_o}, {31'd0, e.last});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic shape, input logic [4:0] sx, input logic [4:0] sy);
    start_i = 1'b1; shape_i = shape; sizeX_i = sx; sizeY_i = sy;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    z_we_i = 1'b1; z_addr_i = a; z_data_i = d;
    tick();
    z_we_i = 1'b0;
  endtask

  task automatic pulse_done();
    conv_done_i = 1'b1;
    tick();
    conv_done_i = 1'b0;
  endtask

  task automatic exp_beat(input logic [DATA_W-1:0] d, input int idx, input logic last);
    beat_t b;
    b.data = d; b.index = ADDR_W'(idx); b.last = last;
    exp_q.push_back(b);
  endtask

  // Bounded wait for done_o, then confirm it is a single-cycle pulse.
  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_done"}, {31'd0, done_o}, 32'd1);
    tick();
    chk({nm, "_done_1cyc"}, {31'd0, done_o}, 32'd0);
    chk({nm, "_idle"}, {31'd0, busy_o}, 32'd0);
    chk({nm, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; start_i = 1'b0; shape_i = 1'b0; sizeX_i = '0; sizeY_i = '0;
    z_we_i = 1'b0; z_addr_i = '0; z_data_i = '0; conv_done_i = 1'b0; m_ready_i = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_flags", {27'd0, busy_o, done_o, ovf_o, order_err_o, len_err_o}, 32'd0);
    rstn = 1'b1;
    tick();

    // 1) full 4x3 -> 6 beats, ready high
    m_ready_i = 1'b1;
    do_start(1'b1, 5'd4, 5'd3);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      exp_beat(16'h1000 + 16'(i), i, i == 5);
      do_write(ADDR_W'(i), 16'h1000 + 16'(i));
    end
    wait_done("t1", 10);
    chk("t1_flags", {29'd0, ovf_o, order_err_o, len_err_o}, 32'd0);

    // 2) same, sizeX=5, ready low until conv_done
    m_ready_i = 1'b0;
    do_start(1'b0, 5'd5, 5'd3);
    for (int i = 0; i < 5; i++) begin
      exp_beat(16'h2000 + 16'(i * 3), i, i == 4);
      do_write(ADDR_W'(i), 16'h2000 + 16'(i * 3));
    end
    chk("t2_valid_held", {31'd0, m_valid_o}, 32'd1);
    chk("t2_busy", {31'd0, busy_o}, 32'd1);
    pulse_done();
    m_ready_i = 1'b1;
    wait_done("t2", 12);
    chk("t2_ovf", {31'd0, ovf_o}, 32'd0);

    // 3) full 8x8 -> 15 samples, ready low: first 8 kept, 7 dropped
    m_ready_i = 1'b0;
    do_start(1'b1, 5'd8, 5'd8);
    for (int i = 0; i < 15; i++) begin
      if (i < 8) exp_beat(16'h3000 + 16'(i), i, 1'b0);
      do_write(ADDR_W'(i), 16'h3000 + 16'(i));
    end
    chk("t3_ovf", {31'd0, ovf_o}, 32'd1);
    chk("t3_order", {31'd0, order_err_o}, 32'd0);
    m_ready_i = 1'b1;
    wait_done("t3", 20);

    // 4) same, sizeX=6, conv_done after 3 writes -> truncated to 3 beats
    m_ready_i = 1'b0;
    do_start(1'b0, 5'd6, 5'd2);
    for (int i = 0; i < 3; i++) begin
      exp_beat(16'h4000 + 16'(i), i, i == 2);
      do_write(ADDR_W'(i), 16'h4000 + 16'(i));
    end
    chk("t4_lenerr_pre", {31'd0, len_err_o}, 32'd0);
    pulse_done();
    chk("t4_lenerr", {31'd0, len_err_o}, 32'd1);
    m_ready_i = 1'b1;
    wait_done("t4", 10);

    // 5) full 2x2 -> 3 samples, addresses 0,1,3
    m_ready_i = 1'b1;
    do_start(1'b1, 5'd2, 5'd2);
    chk("t5_flags_cleared", {29'd0, ovf_o, order_err_o, len_err_o}, 32'd0);
    exp_beat(16'h5A00, 0, 1'b0);
    do_write(6'd0, 16'h5A00);
    exp_beat(16'h5A11, 1, 1'b0);
    do_write(6'd1, 16'h5A11);
    chk("t5_order_ok", {31'd0, order_err_o}, 32'd0);
    exp_beat(16'h5A33, 2, 1'b1);
    do_write(6'd3, 16'h5A33);
    chk("t5_order_err", {31'd0, order_err_o}, 32'd1);
    wait_done("t5", 10);

    // 6a) reset in the middle of DRAIN with data pending
    m_ready_i = 1'b0;
    do_start(1'b1, 5'd3, 5'd3);
    chk("t6_flags_cleared", {31'd0, order_err_o}, 32'd0);
    for (int i = 0; i < 5; i++) do_write(ADDR_W'(i), 16'h6000 + 16'(i));
    chk("t6_valid_pre", {31'd0, m_valid_o}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_valid_rst", {31'd0, m_valid_o}, 32'd0);
    chk("t6_busy_rst", {31'd0, busy_o}, 32'd0);
    tick();
    rstn = 1'b1;
    m_ready_i = 1'b1;
    tick();

    // 6b) zero size -> done next cycle, no beats
    do_start(1'b1, 5'd0, 5'd4);
    chk("t6_zero_done", {31'd0, done_o}, 32'd1);
    chk("t6_zero_valid", {31'd0, m_valid_o}, 32'd0);
    tick();
    chk("t6_zero_done_1cyc", {31'd0, done_o}, 32'd0);
    chk("t6_zero_idle", {31'd0, busy_o}, 32'd0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_conv_z_streamer
`default_nettype wire
